// File: rtl/mem_stage_lsu_if.sv
// Data-bus bundle between the memory-stage LSU (master) and the data memory (slave).
// One request is held stable until the slave answers with bus_ready.
interface mem_stage_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: decodes MIPS loads/stores, runs one bus transaction
// per instruction, stalls the pipeline until the response, returns aligned load data.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instr_m,
  input  logic [31:0]           addr_m,
  input  logic [31:0]           wdata_m,
  input  logic [4:0]            a3_m,
  output logic                  stall_o,
  mem_stage_lsu_if.master       bus,
  output logic [31:0]           ld_data_o,
  output logic [4:0]            ld_a3_o,
  output logic                  ld_valid_o,
  output logic                  adel_o,
  output logic                  ades_o,
  output logic                  bus_err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [31:0]       bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic [4:0]        ld_a3_q, ld_a3_d;
  logic              ld_valid_q, ld_valid_d, bus_err_q, bus_err_d;
  size_e             size_q, size_d;
  logic              sext_q, sext_d, load_q, load_d;
  logic [1:0]        off_q, off_d;

  // Opcode decode
  logic  is_load, is_store, dec_sext, misalign, start;
  size_e dec_size;
  logic  unused_instr;

  assign unused_instr = ^instr_m[25:0];

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    is_load  = 1'b0;
    is_store = 1'b0;
    dec_sext = 1'b0;
    dec_size = SZ_W;
    unique case (instr_m[31:26])
      6'h20: begin is_load  = 1'b1; dec_size = SZ_B; dec_sext = 1'b1; end
      6'h21: begin is_load  = 1'b1; dec_size = SZ_H; dec_sext = 1'b1; end
      6'h23: begin is_load  = 1'b1; dec_size = SZ_W; end
      6'h24: begin is_load  = 1'b1; dec_size = SZ_B; end
      6'h25: begin is_load  = 1'b1; dec_size = SZ_H; end
      6'h28: begin is_store = 1'b1; dec_size = SZ_B; end
      6'h29: begin is_store = 1'b1; dec_size = SZ_H; end
      6'h2B: begin is_store = 1'b1; dec_size = SZ_W; end
      default: ;
    endcase
  end

  assign misalign = (dec_size == SZ_W && addr_m[1:0] != 2'b00) ||
                    (dec_size == SZ_H && addr_m[0]);
  assign start    = (is_load || is_store) && !misalign;

  logic timeout_hit;
  assign timeout_hit = TMO_EN && (cnt_q == TMO_LAST);

  // Lane extraction uses the offset captured at issue, not the live address
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  assign rd_byte = bus.bus_rdata[{off_q, 3'b000} +: 8];
  assign rd_half = bus.bus_rdata[{off_q[1], 4'b0000} +: 16];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      ld_data_q   <= '0;
      ld_a3_q     <= '0;
      ld_valid_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      size_q      <= SZ_W;
      sext_q      <= 1'b0;
      load_q      <= 1'b0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      ld_data_q   <= ld_data_d;
      ld_a3_q     <= ld_a3_d;
      ld_valid_q  <= ld_valid_d;
      bus_err_q   <= bus_err_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      load_q      <= load_d;
      off_q       <= off_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (bus.bus_ready || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_o     = 1'b0;
    adel_o      = 1'b0;
    ades_o      = 1'b0;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    ld_data_d   = ld_data_q;
    ld_a3_d     = ld_a3_q;
    ld_valid_d  = 1'b0;
    bus_err_d   = 1'b0;
    size_d      = size_q;
    sext_d      = sext_q;
    load_d      = load_q;
    off_d       = off_q;
    unique case (state_q)
      IDLE: begin
        adel_o = is_load && misalign;
        ades_o = is_store && misalign;
        if (start) begin
          stall_o    = 1'b1;
          bus_req_d  = 1'b1;
          bus_we_d   = is_store;
          bus_addr_d = {addr_m[31:2], 2'b00};
          cnt_d      = '0;
          size_d     = dec_size;
          sext_d     = dec_sext;
          load_d     = is_load;
          off_d      = addr_m[1:0];
          bus_be_d   = 4'b1111;
          bus_wdata_d = wdata_m;
          if (is_store && dec_size == SZ_B) begin
            bus_be_d    = 4'b0001 << addr_m[1:0];
            bus_wdata_d = {4{wdata_m[7:0]}};
          end else if (is_store && dec_size == SZ_H) begin
            bus_be_d    = addr_m[1] ? 4'b1100 : 4'b0011;
            bus_wdata_d = {2{wdata_m[15:0]}};
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (bus.bus_ready) begin
          bus_req_d = 1'b0;
          if (load_q) begin
            ld_valid_d = 1'b1;
            ld_a3_d    = a3_m;
            unique case (size_q)
              SZ_B:    ld_data_d = {{24{sext_q & rd_byte[7]}}, rd_byte};
              SZ_H:    ld_data_d = {{16{sext_q & rd_half[15]}}, rd_half};
              default: ld_data_d = bus.bus_rdata;
            endcase
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (timeout_hit) begin
            bus_req_d = 1'b0;
            bus_err_d = 1'b1;
            ld_data_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign ld_data_o     = ld_data_q;
  assign ld_a3_o       = ld_a3_q;
  assign ld_valid_o    = ld_valid_q;
  assign bus_err_o     = bus_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a default-timeout instance for the main sequence
// and a TIMEOUT_CYCLES=4 instance for the abort path.
module tb_mem_stage_lsu;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B, OP_NOP = 6'h00;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, addr, wdata;
  logic [4:0]  a3;
  logic        stall, ld_valid, adel, ades, berr;
  logic [31:0] ld_data;
  logic [4:0]  ld_a3;

  logic [31:0] instr_t, addr_t;
  logic        stall_t, ld_valid_t, adel_t, ades_t, berr_t;
  logic [31:0] ld_data_t;
  logic [4:0]  ld_a3_t;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_lsu_if bus_m ();
  mem_stage_lsu_if bus_t ();

  mem_stage_lsu dut (
    .clk(clk), .reset(reset), .instr_m(instr), .addr_m(addr), .wdata_m(wdata), .a3_m(a3),
    .stall_o(stall), .bus(bus_m), .ld_data_o(ld_data), .ld_a3_o(ld_a3),
    .ld_valid_o(ld_valid), .adel_o(adel), .ades_o(ades), .bus_err_o(berr)
  );

  mem_stage_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut_t (
    .clk(clk), .reset(reset), .instr_m(instr_t), .addr_m(addr_t), .wdata_m(32'h0),
    .a3_m(5'd1), .stall_o(stall_t), .bus(bus_t), .ld_data_o(ld_data_t), .ld_a3_o(ld_a3_t),
    .ld_valid_o(ld_valid_t), .adel_o(adel_t), .ades_o(ades_t), .bus_err_o(berr_t)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op);
    return {op, 26'd0};
  endfunction

  initial begin
    reset = 1'b1; instr = mk(OP_NOP); addr = '0; wdata = '0; a3 = '0;
    instr_t = mk(OP_NOP); addr_t = '0;
    bus_m.bus_ready = 1'b0; bus_m.bus_rdata = '0;
    bus_t.bus_ready = 1'b0; bus_t.bus_rdata = 32'h5555_AAAA;
    tick(); tick();
    reset = 1'b0;
    check("rst_req", 32'(bus_m.bus_req), 0);
    check("rst_we", 32'(bus_m.bus_we), 0);
    check("rst_addr", bus_m.bus_addr, 0);
    check("rst_be", 32'(bus_m.bus_be), 0);
    check("rst_wdata", bus_m.bus_wdata, 0);
    check("rst_ld_data", ld_data, 0);
    check("rst_ld_a3", 32'(ld_a3), 0);
    check("rst_ld_valid", 32'(ld_valid), 0);
    check("rst_berr", 32'(berr), 0);
    check("rst_stall", 32'(stall), 0);

    // SW 0x100, ready tied high
    bus_m.bus_ready = 1'b1;
    instr = mk(OP_SW); addr = 32'h100; wdata = 32'hDEAD_BEEF;
    #1;
    check("sw_idle_stall", 32'(stall), 1);
    check("sw_idle_req", 32'(bus_m.bus_req), 0);
    tick();
    instr = mk(OP_NOP);
    check("sw_req", 32'(bus_m.bus_req), 1);
    check("sw_we", 32'(bus_m.bus_we), 1);
    check("sw_be", 32'(bus_m.bus_be), 32'hF);
    check("sw_addr", bus_m.bus_addr, 32'h100);
    check("sw_wdata", bus_m.bus_wdata, 32'hDEAD_BEEF);
    check("sw_busy_stall", 32'(stall), 1);
    tick();
    check("sw_done_req", 32'(bus_m.bus_req), 0);
    check("sw_done_stall", 32'(stall), 0);
    check("sw_done_ldv", 32'(ld_valid), 0);
    tick();
    check("sw_idle2_req", 32'(bus_m.bus_req), 0);
    check("sw_idle2_stall", 32'(stall), 0);

    // SB 0x103: byte lane 3, replicated data
    bus_m.bus_ready = 1'b0;
    instr = mk(OP_SB); addr = 32'h103; wdata = 32'h0000_00A5;
    tick();
    instr = mk(OP_NOP);
    check("sb_be", 32'(bus_m.bus_be), 32'h8);
    check("sb_wdata", bus_m.bus_wdata, 32'hA5A5_A5A5);
    check("sb_addr", bus_m.bus_addr, 32'h100);
    check("sb_we", 32'(bus_m.bus_we), 1);
    bus_m.bus_ready = 1'b1;
    tick(); tick();

    // SH 0x102: upper half lanes
    bus_m.bus_ready = 1'b0;
    instr = mk(OP_SH); addr = 32'h102; wdata = 32'h1234_BEEF;
    tick();
    instr = mk(OP_NOP);
    check("sh_be", 32'(bus_m.bus_be), 32'hC);
    check("sh_wdata", bus_m.bus_wdata, 32'hBEEF_BEEF);
    bus_m.bus_ready = 1'b1;
    tick(); tick();

    // LB 0x201, rdata 0x12348056 -> byte 0x80 sign-extended
    bus_m.bus_rdata = 32'h1234_8056;
    instr = mk(OP_LB); addr = 32'h201; a3 = 5'd7;
    tick();
    instr = mk(OP_NOP);
    check("lb_we", 32'(bus_m.bus_we), 0);
    check("lb_be", 32'(bus_m.bus_be), 32'hF);
    check("lb_addr", bus_m.bus_addr, 32'h200);
    check("lb_busy_ldv", 32'(ld_valid), 0);
    tick();
    check("lb_ldv", 32'(ld_valid), 1);
    check("lb_data", ld_data, 32'hFFFF_FF80);
    check("lb_a3", 32'(ld_a3), 7);
    tick();
    check("lb_ldv_pulse", 32'(ld_valid), 0);

    // LBU same stimulus -> zero-extended
    instr = mk(OP_LBU); addr = 32'h201; a3 = 5'd9;
    tick();
    instr = mk(OP_NOP);
    tick();
    check("lbu_ldv", 32'(ld_valid), 1);
    check("lbu_data", ld_data, 32'h0000_0080);
    check("lbu_a3", 32'(ld_a3), 9);
    tick();

    // LH 0x202 -> upper half 0x1234
    instr = mk(OP_LH); addr = 32'h202; a3 = 5'd3;
    tick();
    instr = mk(OP_NOP);
    tick();
    check("lh_ldv", 32'(ld_valid), 1);
    check("lh_data", ld_data, 32'h0000_1234);
    tick();

    // LW with ready delayed 5 cycles, address changed mid-BUSY
    bus_m.bus_ready = 1'b0; bus_m.bus_rdata = 32'hCAFE_F00D;
    instr = mk(OP_LW); addr = 32'h300; a3 = 5'd12;
    #1;
    check("lw_stall_idle", 32'(stall), 1);
    tick();
    addr = 32'h444;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("lw_addr_hold%0d", i), bus_m.bus_addr, 32'h300);
      check($sformatf("lw_stall%0d", i), 32'(stall), 1);
      tick();
    end
    bus_m.bus_ready = 1'b1;
    check("lw_stall_last", 32'(stall), 1);
    check("lw_addr_last", bus_m.bus_addr, 32'h300);
    tick();
    instr = mk(OP_NOP);
    check("lw_done_stall", 32'(stall), 0);
    check("lw_ldv", 32'(ld_valid), 1);
    check("lw_data", ld_data, 32'hCAFE_F00D);
    check("lw_a3", 32'(ld_a3), 12);
    bus_m.bus_ready = 1'b0;
    tick();

    // Misaligned accesses
    instr = mk(OP_LW); addr = 32'h202;
    #1;
    check("adel", 32'(adel), 1);
    check("adel_ades", 32'(ades), 0);
    check("adel_stall", 32'(stall), 0);
    tick();
    check("adel_req", 32'(bus_m.bus_req), 0);
    instr = mk(OP_SH); addr = 32'h101;
    #1;
    check("ades", 32'(ades), 1);
    check("ades_adel", 32'(adel), 0);
    check("ades_stall", 32'(stall), 0);
    tick();
    check("ades_req", 32'(bus_m.bus_req), 0);
    instr = mk(OP_NOP);

    // Timeout instance: 4 BUSY cycles then abort
    instr_t = mk(OP_LW); addr_t = 32'h40;
    tick();
    instr_t = mk(OP_NOP);
    check("to_req", 32'(bus_t.bus_req), 1);
    tick(); tick(); tick();
    check("to_req4", 32'(bus_t.bus_req), 1);
    check("to_err_early", 32'(berr_t), 0);
    tick();
    check("to_err", 32'(berr_t), 1);
    check("to_ldv", 32'(ld_valid_t), 0);
    check("to_req_drop", 32'(bus_t.bus_req), 0);
    check("to_ld_data", ld_data_t, 0);
    check("to_stall", 32'(stall_t), 0);
    bus_t.bus_ready = 1'b1;
    tick();
    check("to_err_pulse", 32'(berr_t), 0);
    check("to_late_ldv", 32'(ld_valid_t), 0);
    tick();
    check("to_late_ldv2", 32'(ld_valid_t), 0);
    check("to_late_req", 32'(bus_t.bus_req), 0);
    bus_t.bus_ready = 1'b0;

    // Reset during BUSY discards the outstanding access
    bus_m.bus_rdata = 32'h1122_3344;
    instr = mk(OP_LW); addr = 32'h500; a3 = 5'd4;
    tick();
    instr = mk(OP_NOP);
    check("rb_req", 32'(bus_m.bus_req), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rb_req_drop", 32'(bus_m.bus_req), 0);
    check("rb_addr", bus_m.bus_addr, 0);
    bus_m.bus_ready = 1'b1;
    tick();
    check("rb_late_ldv", 32'(ld_valid), 0);
    check("rb_late_data", ld_data, 0);
    tick();
    check("rb_late_ldv2", 32'(ld_valid), 0);

    // Back-to-back stores: second issues in the IDLE cycle after DONE
    instr = mk(OP_SW); addr = 32'h10; wdata = 32'h1;
    tick();
    addr = 32'h20; wdata = 32'h2;
    check("bb_addr1", bus_m.bus_addr, 32'h10);
    tick();
    check("bb_done_stall", 32'(stall), 0);
    tick();
    check("bb_idle_stall", 32'(stall), 1);
    check("bb_idle_req", 32'(bus_m.bus_req), 0);
    tick();
    instr = mk(OP_NOP);
    check("bb_req2", 32'(bus_m.bus_req), 1);
    check("bb_addr2", bus_m.bus_addr, 32'h20);
    check("bb_wdata2", bus_m.bus_wdata, 32'h2);
    tick(); tick();
    check("bb_end_req", 32'(bus_m.bus_req), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
